// File: rtl/lsu_load_port_arbiter.sv
// Two-requester load-port arbiter in front of a single LSU request port.
// Round-robin grant with zero-latency issue from IDLE, owner held until the
// LSU completes or the transaction is killed/flushed; killed transactions
// wait in DRAIN until the LSU signals ready. A saturating busy counter
// raises a sticky timeout error when a transaction lingers too long.
module lsu_load_port_arbiter #(
    parameter int unsigned REQ_W   = 32'd160,
    parameter int unsigned RESP_W  = 32'd72,
    parameter int unsigned TIMEOUT = 32'd255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              Flush,
    input  logic [1:0]        ReqValid,
    input  logic [1:0]        ReqKilled,
    input  logic [REQ_W-1:0]  ReqPayload0,
    input  logic [REQ_W-1:0]  ReqPayload1,
    output logic              LSUreqValid,
    output logic              LSUreqKilled,
    output logic [REQ_W-1:0]  LSUreqPayload,
    input  logic              LSUrespReady,
    input  logic              LSUrespDone,
    input  logic [RESP_W-1:0] LSUrespPayload,
    output logic [1:0]        RespReady,
    output logic [1:0]        RespDone,
    output logic [RESP_W-1:0] RespPayload,
    output logic              Owner,
    output logic              GrantBusy,
    output logic              ErrTimeout
);

    localparam logic [7:0] TIMEOUT_C = 8'(TIMEOUT);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_BUSY  = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t     r_state;
    state_t     w_state_nxt;
    logic       r_owner;
    logic       r_ptr;
    logic [7:0] r_busy_cnt;
    logic       r_err;

    logic [1:0] w_elig;
    logic       w_win_valid;
    logic       w_winner;
    logic [1:0] w_own_sel;
    logic       w_kill;
    logic       w_done;

    // Request qualification, round-robin winner and owner-side completion/kill decode.
    always_comb begin
        w_elig      = ReqValid & ~ReqKilled & {2{~Flush}};
        w_win_valid = |w_elig;
        if (w_elig[r_ptr]) begin
            w_winner = r_ptr;
        end else begin
            w_winner = ~r_ptr;
        end
        w_own_sel = {r_owner, ~r_owner};
        w_kill    = ReqKilled[r_owner] | Flush;
        w_done    = LSUrespDone & ReqValid[r_owner] & ~w_kill;
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic: kill beats done; a kill seen together with LSU ready skips DRAIN.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_win_valid) begin
                    w_state_nxt = S_BUSY;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_BUSY: begin
                if (w_kill) begin
                    if (LSUrespReady) begin
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_state_nxt = S_DRAIN;
                    end
                end else if (w_done) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_state_nxt = S_BUSY;
                end
            end
            S_DRAIN: begin
                if (LSUrespReady) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_state_nxt = S_DRAIN;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Owner capture on grant and pointer hand-off to the other requester when a transaction ends.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_owner <= 1'b0;
            r_ptr   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_win_valid) begin
                        r_owner <= w_winner;
                    end
                end
                S_BUSY: begin
                    if (w_kill || w_done) begin
                        r_ptr <= ~r_owner;
                    end
                end
                default: begin
                    r_owner <= r_owner;
                    r_ptr   <= r_ptr;
                end
            endcase
        end
    end

    // Busy-cycle counter: cleared on grant, counts BUSY/DRAIN cycles, saturates at all-ones.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_busy_cnt <= 8'd0;
        end else if ((r_state == S_IDLE) && w_win_valid) begin
            r_busy_cnt <= 8'd0;
        end else if ((r_state != S_IDLE) && (r_busy_cnt != 8'hFF)) begin
            r_busy_cnt <= r_busy_cnt + 8'd1;
        end
    end

    // Sticky timeout flag; only reset clears it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_err <= 1'b0;
        end else if (r_busy_cnt == TIMEOUT_C) begin
            r_err <= 1'b1;
        end
    end

    // Output decode; every output is forced low while reset is asserted.
    always_comb begin
        LSUreqValid   = 1'b0;
        LSUreqKilled  = 1'b0;
        LSUreqPayload = {REQ_W{1'b0}};
        RespReady     = 2'b00;
        RespDone      = 2'b00;
        RespPayload   = {RESP_W{1'b0}};
        Owner         = 1'b0;
        GrantBusy     = 1'b0;
        ErrTimeout    = 1'b0;
        if (!rst) begin
            LSUreqValid = 1'b0;
        end else begin
            RespPayload = LSUrespPayload;
            Owner       = r_owner;
            GrantBusy   = (r_state != S_IDLE);
            ErrTimeout  = r_err;
            RespReady   = ({2{GrantBusy & LSUrespReady}} & w_own_sel) | ReqKilled | {2{Flush}};
            case (r_state)
                S_IDLE: begin
                    LSUreqValid = w_win_valid;
                    if (!w_win_valid) begin
                        LSUreqPayload = {REQ_W{1'b0}};
                    end else if (w_winner) begin
                        LSUreqPayload = ReqPayload1;
                    end else begin
                        LSUreqPayload = ReqPayload0;
                    end
                end
                S_BUSY: begin
                    LSUreqValid  = ReqValid[r_owner];
                    LSUreqKilled = w_kill;
                    if (r_owner) begin
                        LSUreqPayload = ReqPayload1;
                    end else begin
                        LSUreqPayload = ReqPayload0;
                    end
                    RespDone = w_own_sel & {2{w_done}};
                end
                S_DRAIN: begin
                    LSUreqValid  = 1'b0;
                    LSUreqKilled = 1'b1;
                end
                default: begin
                    LSUreqValid  = 1'b0;
                    LSUreqKilled = 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_load_port_arbiter.sv
// Self-checking bench for lsu_load_port_arbiter: grant payloads go through a
// scoreboard queue, everything else is checked inline against bench constants.
module tb_lsu_load_port_arbiter;

    localparam int REQ_W  = 160;
    localparam int RESP_W = 72;

    logic              clk = 1'b0;
    logic              rst;
    logic              Flush;
    logic [1:0]        ReqValid;
    logic [1:0]        ReqKilled;
    logic [REQ_W-1:0]  ReqPayload0;
    logic [REQ_W-1:0]  ReqPayload1;
    logic              LSUreqValid;
    logic              LSUreqKilled;
    logic [REQ_W-1:0]  LSUreqPayload;
    logic              LSUrespReady;
    logic              LSUrespDone;
    logic [RESP_W-1:0] LSUrespPayload;
    logic [1:0]        RespReady;
    logic [1:0]        RespDone;
    logic [RESP_W-1:0] RespPayload;
    logic              Owner;
    logic              GrantBusy;
    logic              ErrTimeout;

    int n_total = 0;
    int n_bad   = 0;
    logic [REQ_W-1:0] exp_q[$];

    lsu_load_port_arbiter dut (
        .clk            (clk),
        .rst            (rst),
        .Flush          (Flush),
        .ReqValid       (ReqValid),
        .ReqKilled      (ReqKilled),
        .ReqPayload0    (ReqPayload0),
        .ReqPayload1    (ReqPayload1),
        .LSUreqValid    (LSUreqValid),
        .LSUreqKilled   (LSUreqKilled),
        .LSUreqPayload  (LSUreqPayload),
        .LSUrespReady   (LSUrespReady),
        .LSUrespDone    (LSUrespDone),
        .LSUrespPayload (LSUrespPayload),
        .RespReady      (RespReady),
        .RespDone       (RespDone),
        .RespPayload    (RespPayload),
        .Owner          (Owner),
        .GrantBusy      (GrantBusy),
        .ErrTimeout     (ErrTimeout)
    );

    always #5 clk = ~clk;

    // Single comparison point: counts and reports.
    task automatic check_eq(input string tag, input logic [159:0] got, input logic [159:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic check_all_zero(input string pfx);
        check_eq({pfx, "_reqvalid"},  160'(LSUreqValid),   160'd0);
        check_eq({pfx, "_reqkilled"}, 160'(LSUreqKilled),  160'd0);
        check_eq({pfx, "_reqpay"},    160'(LSUreqPayload), 160'd0);
        check_eq({pfx, "_respready"}, 160'(RespReady),     160'd0);
        check_eq({pfx, "_respdone"},  160'(RespDone),      160'd0);
        check_eq({pfx, "_resppay"},   160'(RespPayload),   160'd0);
        check_eq({pfx, "_busy"},      160'(GrantBusy),     160'd0);
        check_eq({pfx, "_owner"},     160'(Owner),         160'd0);
        check_eq({pfx, "_err"},       160'(ErrTimeout),    160'd0);
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    task automatic new_payloads();
        ReqPayload0 = {$urandom, $urandom, $urandom, $urandom, $urandom};
        ReqPayload1 = {$urandom, $urandom, $urandom, $urandom, $urandom};
        ReqPayload0[159:152] = 8'hA0;
        ReqPayload1[159:152] = 8'hB1;
    endtask

    // Scoreboard monitor: every IDLE-state grant must match the oldest expected payload.
    always @(negedge clk) begin
        if (rst === 1'b1 && LSUreqValid === 1'b1 && GrantBusy === 1'b0) begin
            if (exp_q.size() == 0) begin
                check_eq("sb_grant_expected", 160'(exp_q.size()), 160'd1);
            end else begin
                check_eq("sb_grant_payload", LSUreqPayload, exp_q.pop_front());
            end
        end
    end

    initial begin
        rst            = 1'b0;
        Flush          = 1'b1;
        ReqValid       = 2'b11;
        ReqKilled      = 2'b10;
        LSUrespReady   = 1'b1;
        LSUrespDone    = 1'b1;
        LSUrespPayload = 72'h12_3456_789A_BCDE_F012;
        new_payloads();
        repeat (2) @(posedge clk);
        #2;
        check_all_zero("rst");

        // Both eligible after reset: requester 0 first, done three cycles later, then requester 1.
        nxt();
        rst = 1'b1; Flush = 1'b0; ReqKilled = 2'b00;
        LSUrespReady = 1'b0; LSUrespDone = 1'b0; ReqValid = 2'b11;
        exp_q.push_back(ReqPayload0);
        smp();
        check_eq("t37_grant_valid", 160'(LSUreqValid), 160'd1);
        check_eq("t37_rr_idle",     160'(RespReady),   160'd0);
        nxt(); smp();
        check_eq("t37_owner",    160'(Owner),     160'd0);
        check_eq("t37_busy",     160'(GrantBusy), 160'd1);
        check_eq("t37_rr_stall", 160'(RespReady), 160'd0);
        check_eq("t37_busy_pay", LSUreqPayload,   ReqPayload0);
        nxt(); smp();
        nxt();
        LSUrespDone = 1'b1; LSUrespReady = 1'b1;
        smp();
        check_eq("t37_done",    160'(RespDone),    160'd1);
        check_eq("t37_rr_done", 160'(RespReady),   160'd1);
        check_eq("t37_resppay", 160'(RespPayload), 160'(LSUrespPayload));
        nxt();
        LSUrespDone = 1'b0; LSUrespReady = 1'b0;
        exp_q.push_back(ReqPayload1);
        smp();
        check_eq("t37_grant1_valid", 160'(LSUreqValid), 160'd1);
        nxt(); smp();
        check_eq("t37_owner1", 160'(Owner), 160'd1);

        // Kill on owner 1 together with done: kill wins, then DRAIN until ready.
        nxt();
        ReqKilled = 2'b10; LSUrespDone = 1'b1;
        smp();
        check_eq("t38_done",   160'(RespDone),     160'd0);
        check_eq("t38_killed", 160'(LSUreqKilled), 160'd1);
        check_eq("t38_rr",     160'(RespReady),    160'd2);
        nxt();
        ReqKilled = 2'b00; LSUrespDone = 1'b0;
        smp();
        check_eq("t38_drain_busy",   160'(GrantBusy),    160'd1);
        check_eq("t38_drain_valid",  160'(LSUreqValid),  160'd0);
        check_eq("t38_drain_killed", 160'(LSUreqKilled), 160'd1);
        nxt();
        LSUrespReady = 1'b1;
        smp();
        check_eq("t38_drain_nogrant", 160'(LSUreqValid), 160'd0);
        nxt();
        LSUrespReady = 1'b0;
        new_payloads();
        exp_q.push_back(ReqPayload0);
        smp();
        check_eq("t38_regrant_valid", 160'(LSUreqValid), 160'd1);
        nxt(); smp();
        check_eq("t38_ptr_owner0", 160'(Owner), 160'd0);

        // Flush in BUSY with ready low: DRAIN holds, then flush in IDLE blocks the grant.
        nxt();
        Flush = 1'b1; ReqValid = 2'b01;
        smp();
        check_eq("t39_killed", 160'(LSUreqKilled), 160'd1);
        check_eq("t39_rr",     160'(RespReady),    160'd3);
        check_eq("t39_done",   160'(RespDone),     160'd0);
        nxt();
        Flush = 1'b0;
        for (int i = 0; i < 2; i++) begin
            smp();
            check_eq("t39_drain_busy",  160'(GrantBusy),   160'd1);
            check_eq("t39_drain_valid", 160'(LSUreqValid), 160'd0);
            nxt();
        end
        LSUrespReady = 1'b1; Flush = 1'b1; ReqValid = 2'b11;
        smp();
        check_eq("t39_exit_nogrant", 160'(LSUreqValid), 160'd0);
        nxt();
        LSUrespReady = 1'b0;
        smp();
        check_eq("t32_idle",      160'(GrantBusy),   160'd0);
        check_eq("t32_flush_nog", 160'(LSUreqValid), 160'd0);
        check_eq("t32_flush_rr",  160'(RespReady),   160'd3);
        nxt();
        Flush = 1'b0;
        exp_q.push_back(ReqPayload1);
        smp();
        check_eq("t39_grant_valid", 160'(LSUreqValid), 160'd1);
        nxt(); smp();
        check_eq("t39_owner1", 160'(Owner), 160'd1);

        // Owner drops valid without kill: request valid follows, state holds, done ignored.
        nxt();
        ReqValid = 2'b01; LSUrespDone = 1'b1;
        smp();
        check_eq("t31_valid_low", 160'(LSUreqValid), 160'd0);
        check_eq("t31_no_done",   160'(RespDone),    160'd0);
        nxt();
        LSUrespDone = 1'b0;
        smp();
        check_eq("t31_hold_busy",  160'(GrantBusy), 160'd1);
        check_eq("t31_hold_owner", 160'(Owner),     160'd1);
        nxt();
        ReqValid = 2'b10; LSUrespDone = 1'b1;
        smp();
        check_eq("t31_done", 160'(RespDone), 160'd2);

        // Only requester 1 valid: immediate grant to 1, then hold long enough to time out.
        nxt();
        LSUrespDone = 1'b0;
        new_payloads();
        exp_q.push_back(ReqPayload1);
        smp();
        check_eq("t42_grant_valid", 160'(LSUreqValid), 160'd1);
        check_eq("t42_rr0_idle",    160'(RespReady[0]), 160'd0);
        for (int i = 0; i < 260; i++) begin
            nxt(); smp();
            if (i == 200) check_eq("t40_err_early", 160'(ErrTimeout), 160'd0);
            if ((i % 64) == 0) check_eq("t42_rr0_busy", 160'(RespReady[0]), 160'd0);
        end
        check_eq("t40_err_set",  160'(ErrTimeout), 160'd1);
        check_eq("t40_still_busy", 160'(GrantBusy), 160'd1);
        nxt();
        LSUrespDone = 1'b1;
        smp();
        check_eq("t40_done", 160'(RespDone), 160'd2);
        nxt();
        LSUrespDone = 1'b0; ReqValid = 2'b00;
        smp();
        check_eq("t40_idle",       160'(GrantBusy),  160'd0);
        check_eq("t40_err_sticky", 160'(ErrTimeout), 160'd1);

        // Asynchronous reset mid-BUSY: outputs drop without a clock edge.
        nxt();
        ReqValid = 2'b11;
        exp_q.push_back(ReqPayload0);
        smp();
        nxt(); smp();
        nxt();
        LSUrespDone = 1'b1; LSUrespReady = 1'b1; ReqKilled = 2'b10;
        #2;
        rst = 1'b0;
        #1;
        check_all_zero("t41");
        nxt();
        LSUrespDone = 1'b0; LSUrespReady = 1'b0; ReqKilled = 2'b00;
        nxt();
        rst = 1'b1;
        exp_q.push_back(ReqPayload0);
        smp();
        check_eq("t41_idle_after", 160'(GrantBusy),   160'd0);
        check_eq("t41_regrant",    160'(LSUreqValid), 160'd1);
        nxt(); smp();
        check_eq("t41_owner0", 160'(Owner), 160'd0);
        nxt();
        LSUrespDone = 1'b1;
        smp();
        check_eq("t41_done", 160'(RespDone), 160'd1);
        nxt();
        LSUrespDone = 1'b0; ReqValid = 2'b00;
        smp();
        check_eq("sb_drained", 160'(exp_q.size()), 160'd0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
